// File: rtl/mc_tag_ctrl_pkg.sv
// Shared definitions for the cache tag-store sequencer: FSM encoding and
// width helpers used by the controller and the cache top.
package mc_tag_ctrl_pkg;

    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_CMP   = 3'd2;
    localparam logic [2:0] ST_RSP   = 3'd3;
    localparam logic [2:0] ST_FILL  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;

    // One tag RAM entry per way is {valid, tag}.
    function automatic int entry_bits(input int tag_w);
        return tag_w + 1;
    endfunction

    // Way index width, never narrower than one bit so WAYS=1 still has a port.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/mc_tag_match.sv
// Single-way tag comparator: hit when the stored entry is valid and its tag
// equals the looked-up tag.
module mc_tag_match #(
    parameter int TAG_WIDTH = 12
) (
    input  logic [TAG_WIDTH-1:0] ref_tag,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic                 valid,
    output logic                 match
);

    assign match = valid && (tag == ref_tag);

endmodule

// File: rtl/mc_tag_ctrl.sv
// Tag-store sequencer: post-reset invalidate sweep, on-demand flush, lookup
// against a 1-cycle tag RAM, victim allocation and tag commit after refill.
module mc_tag_ctrl
    import mc_tag_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = 12,
    parameter int IDX_WIDTH = 7,
    parameter int WAYS      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [IDX_WIDTH-1:0]                req_idx,
    input  logic [TAG_WIDTH-1:0]                req_tag,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_hit,
    output logic [way_bits(WAYS)-1:0]           rsp_way,
    input  logic                                fill_done,
    input  logic                                fill_abort,
    input  logic                                flush_req,
    output logic                                busy,
    output logic [IDX_WIDTH-1:0]                tr_addr,
    output logic                                tr_re,
    input  logic [WAYS*entry_bits(TAG_WIDTH)-1:0] tr_rdata,
    output logic [WAYS-1:0]                     tr_we,
    output logic [entry_bits(TAG_WIDTH)-1:0]    tr_wdata
);

    localparam int EW    = entry_bits(TAG_WIDTH);
    localparam int WAY_W = way_bits(WAYS);

    logic [2:0]           state;
    logic [IDX_WIDTH-1:0] flush_cnt;
    logic [WAY_W-1:0]     vptr;

    logic [IDX_WIDTH-1:0] idx_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 hit_q;
    logic [WAY_W-1:0]     way_q;

    logic [WAYS-1:0]      match;
    logic [WAYS-1:0]      way_vld;
    logic                 hit_any;
    logic                 inv_found;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     victim;
    logic                 accept;

    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
        assign way_vld[gw] = tr_rdata[gw*EW + TAG_WIDTH];
        mc_tag_match #(.TAG_WIDTH(TAG_WIDTH)) u_match (
            .ref_tag (tag_q),
            .tag     (tr_rdata[gw*EW +: TAG_WIDTH]),
            .valid   (way_vld[gw]),
            .match   (match[gw])
        );
    end

    // Scan from the top way down so the lowest-index candidate wins.
    always_comb begin
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
            if (!way_vld[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign hit_any = |match;
    assign victim  = inv_found ? inv_way : vptr;
    assign accept  = (state == ST_IDLE) && req_valid && !flush_req;

    always_comb begin
        req_ready = (state == ST_IDLE) && !flush_req;
        tr_re     = accept;
        busy      = (state != ST_IDLE);
        rsp_valid = (state == ST_RSP);
        rsp_hit   = rsp_valid && hit_q;
        rsp_way   = rsp_valid ? way_q : '0;
        tr_addr   = idx_q;
        tr_we     = '0;
        tr_wdata  = '0;
        case (state)
            ST_FLUSH: begin
                tr_addr = flush_cnt;
                tr_we   = '1;
            end
            ST_IDLE:  tr_addr = req_idx;
            ST_WRITE: begin
                for (int w = 0; w < WAYS; w++) tr_we[w] = (way_q == WAY_W'(w));
                tr_wdata = {1'b1, tag_q};
            end
            default: ;
        endcase
    end

    // Control state: FSM, sweep counter, round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            vptr      <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (&flush_cnt) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush_req)      state <= ST_FLUSH;
                    else if (req_valid) state <= ST_CMP;
                end
                ST_CMP: begin
                    if (!hit_any && !inv_found && (WAYS > 1)) vptr <= vptr + 1'b1;
                    state <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) state <= hit_q ? ST_IDLE : ST_FILL;
                end
                ST_FILL: begin
                    if (fill_abort)     state <= ST_IDLE;
                    else if (fill_done) state <= ST_WRITE;
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_FLUSH;
            endcase
        end
    end

    // Datapath captures: request on accept, lookup result at compare.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= req_idx;
            tag_q <= req_tag;
        end
        if (state == ST_CMP) begin
            hit_q <= hit_any;
            way_q <= hit_any ? hit_way : victim;
        end
    end

endmodule

// File: tb/tb_mc_tag_ctrl.sv
// Directed bench for mc_tag_ctrl with a behavioural 1-cycle tag RAM.
module tb_mc_tag_ctrl;

    localparam int TW = 12;
    localparam int IW = 3;
    localparam int NW = 2;
    localparam int EW = TW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_idx = '0;
    logic [TW-1:0] req_tag = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit;
    logic [0:0]    rsp_way;
    logic          fill_done = 1'b0;
    logic          fill_abort = 1'b0;
    logic          flush_req = 1'b0;
    logic          busy;
    logic [IW-1:0] tr_addr;
    logic          tr_re;
    logic [NW*EW-1:0] tr_rdata;
    logic [NW-1:0] tr_we;
    logic [EW-1:0] tr_wdata;

    int tests = 0;
    int fails = 0;

    logic [NW*EW-1:0] mem [0:(1<<IW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tr_re) tr_rdata <= mem[tr_addr];
        for (int w = 0; w < NW; w++)
            if (tr_we[w]) mem[tr_addr][w*EW +: EW] <= tr_wdata;
    end

    mc_tag_ctrl #(.TAG_WIDTH(TW), .IDX_WIDTH(IW), .WAYS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .fill_done(fill_done), .fill_abort(fill_abort),
        .flush_req(flush_req), .busy(busy),
        .tr_addr(tr_addr), .tr_re(tr_re), .tr_rdata(tr_rdata),
        .tr_we(tr_we), .tr_wdata(tr_wdata)
    );

    // act: 0 = none (hit expected), 1 = fill_done, 2 = fill_abort, 3 = both
    typedef struct {
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        int            act;
        int            wait_cyc;
        logic          exp_hit;
        logic          exp_way;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string name);
        for (int i = 0; i < (1 << IW); i++) begin
            @(negedge clk);
            chk($sformatf("%s_we%0d", name, i), 32'(tr_we), 32'h3);
            chk($sformatf("%s_addr%0d", name, i), 32'(tr_addr), 32'(i));
            chk($sformatf("%s_wdata%0d", name, i), 32'(tr_wdata), 32'h0);
            chk($sformatf("%s_busy%0d", name, i), 32'(busy), 32'h1);
            step();
        end
        @(negedge clk);
        chk({name, "_idle_busy"}, 32'(busy), 32'h0);
        chk({name, "_idle_ready"}, 32'(req_ready), 32'h1);
    endtask

    task automatic do_lookup(input vec_t v, input int n);
        string p;
        p = $sformatf("v%0d", n);
        step();
        req_valid = 1'b1;
        req_idx   = v.idx;
        req_tag   = v.tag;
        @(negedge clk);
        chk({p, "_ready"}, 32'(req_ready), 32'h1);
        chk({p, "_re"}, 32'(tr_re), 32'h1);
        chk({p, "_raddr"}, 32'(tr_addr), 32'(v.idx));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk({p, "_cmp_rspv"}, 32'(rsp_valid), 32'h0);
        chk({p, "_cmp_ready"}, 32'(req_ready), 32'h0);
        step();
        @(negedge clk);
        chk({p, "_rspv"}, 32'(rsp_valid), 32'h1);
        chk({p, "_hit"}, 32'(rsp_hit), 32'(v.exp_hit));
        chk({p, "_way"}, 32'(rsp_way), 32'(v.exp_way));
        chk({p, "_rsp_we"}, 32'(tr_we), 32'h0);
        step();
        @(negedge clk);
        chk({p, "_hold_rspv"}, 32'(rsp_valid), 32'h1);
        chk({p, "_hold_way"}, 32'(rsp_way), 32'(v.exp_way));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        if (v.exp_hit) begin
            chk({p, "_done_busy"}, 32'(busy), 32'h0);
            chk({p, "_done_we"}, 32'(tr_we), 32'h0);
            return;
        end
        for (int k = 0; k < v.wait_cyc; k++) begin
            chk({p, "_fill_we"}, 32'(tr_we), 32'h0);
            chk({p, "_fill_busy"}, 32'(busy), 32'h1);
            step();
            @(negedge clk);
        end
        fill_done  = v.act[0];
        fill_abort = v.act[1];
        step();
        fill_done  = 1'b0;
        fill_abort = 1'b0;
        @(negedge clk);
        if (v.act == 1) begin
            chk({p, "_wr_we"}, 32'(tr_we), 32'(2'b01 << v.exp_way));
            chk({p, "_wr_addr"}, 32'(tr_addr), 32'(v.idx));
            chk({p, "_wr_data"}, 32'(tr_wdata), 32'({1'b1, v.tag}));
            step();
            @(negedge clk);
        end else begin
            chk({p, "_nowr_we"}, 32'(tr_we), 32'h0);
        end
        chk({p, "_end_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{idx: 3'd5, tag: 12'h123, act: 1, wait_cyc: 4, exp_hit: 1'b0, exp_way: 1'b0};
        vecs[1]  = '{idx: 3'd5, tag: 12'h123, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b0};
        vecs[2]  = '{idx: 3'd5, tag: 12'h456, act: 1, wait_cyc: 1, exp_hit: 1'b0, exp_way: 1'b1};
        vecs[3]  = '{idx: 3'd5, tag: 12'h456, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b1};
        vecs[4]  = '{idx: 3'd5, tag: 12'h789, act: 2, wait_cyc: 2, exp_hit: 1'b0, exp_way: 1'b0};
        vecs[5]  = '{idx: 3'd5, tag: 12'h789, act: 2, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b1};
        vecs[6]  = '{idx: 3'd2, tag: 12'h0ab, act: 3, wait_cyc: 1, exp_hit: 1'b0, exp_way: 1'b0};
        vecs[7]  = '{idx: 3'd2, tag: 12'h0ab, act: 1, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b0};
        vecs[8]  = '{idx: 3'd2, tag: 12'h0ab, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b0};
        vecs[9]  = '{idx: 3'd5, tag: 12'h123, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b0};
        vecs[10] = '{idx: 3'd5, tag: 12'h789, act: 1, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b0};
        vecs[11] = '{idx: 3'd5, tag: 12'h123, act: 2, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b1};
        vecs[12] = '{idx: 3'd5, tag: 12'h789, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b0};

        // Reset values while rst is held.
        #12;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_we", 32'(tr_we), 32'h3);
        chk("rst_addr", 32'(tr_addr), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rspv", 32'(rsp_valid), 32'h0);
        chk("rst_hit", 32'(rsp_hit), 32'h0);
        chk("rst_re", 32'(tr_re), 32'h0);
        step();
        rst = 1'b0;
        sweep_check("init");

        for (int i = 0; i < 13; i++) do_lookup(vecs[i], i);

        // Flush has priority over a simultaneous request.
        step();
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_idx   = 3'd5;
        req_tag   = 12'h789;
        @(negedge clk);
        chk("flush_ready", 32'(req_ready), 32'h0);
        chk("flush_re", 32'(tr_re), 32'h0);
        step();
        flush_req = 1'b0;
        req_valid = 1'b0;
        sweep_check("flush");
        do_lookup('{idx: 3'd5, tag: 12'h789, act: 2, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b0}, 100);

        // Reset in the middle of a fill.
        step();
        req_valid = 1'b1;
        req_idx   = 3'd1;
        req_tag   = 12'h321;
        step();
        req_valid = 1'b0;
        step();
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("mid_fill_busy", 32'(busy), 32'h1);
        chk("mid_fill_rspv", 32'(rsp_valid), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rspv", 32'(rsp_valid), 32'h0);
        chk("mid_rst_we", 32'(tr_we), 32'h3);
        chk("mid_rst_addr", 32'(tr_addr), 32'h0);
        step();
        rst = 1'b0;
        sweep_check("rst2");
        do_lookup('{idx: 3'd1, tag: 12'h321, act: 1, wait_cyc: 0, exp_hit: 1'b0, exp_way: 1'b0}, 101);
        do_lookup('{idx: 3'd1, tag: 12'h321, act: 0, wait_cyc: 0, exp_hit: 1'b1, exp_way: 1'b0}, 102);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_tag_ctrl.md
Name: mc_tag_ctrl

Overview:
Sequencer for the set-associative tag store of the memory cache. It accepts lookup requests and reads one set from an external 1-cycle-latency tag RAM. It compares all ways in parallel using per-way tag matchers, returns hit/way or miss/victim, and on a miss waits for the refill engine before writing the new tag. It also owns tag RAM initialisation and flushing: an automatic invalidate sweep after reset, plus on-demand flushes.

Parameters:
TAG_WIDTH, 12, tag bits stored per way
IDX_WIDTH, 7, set index bits (2^IDX_WIDTH sets)
WAYS, 2, associativity; power of two, 1..8

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  lookup request valid
req_ready  out  1  lookup accepted this cycle (valid & ready)
req_idx  in  IDX_WIDTH  set index
req_tag  in  TAG_WIDTH  tag to look up
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  result consumed
rsp_hit  out  1  1 = hit, 0 = miss
rsp_way  out  log2(WAYS) (min 1)  hit way, or allocated victim way on miss
fill_done  in  1  refill of the missed line complete; commit tag
fill_abort  in  1  refill failed; leave tag store unchanged
flush_req  in  1  pulse: invalidate every set
busy  out  1  controller not in IDLE
tr_addr  out  IDX_WIDTH  tag RAM address
tr_re  out  1  tag RAM read enable
tr_rdata  in  WAYS*(TAG_WIDTH+1)  per way {valid, tag}; way w at [w*(TAG_WIDTH+1) +: TAG_WIDTH+1]
tr_we  out  WAYS  per-way write enable
tr_wdata  out  TAG_WIDTH+1  {valid, tag} written to the enabled ways

Behaviour:
- Reset is asynchronous and active-high, on rst.
- Reset values: state=FLUSH, flush counter=0, victim pointer=0. All outputs are 0, except busy=1 and tr_we=all-ones (FLUSH drives the writes).
- FLUSH:
  - tr_addr = counter, tr_we = all-ones, tr_wdata = 0; the counter increments every cycle.
  - After writing set 2^IDX_WIDTH-1, the counter wraps to 0 and the state goes to IDLE. A sweep takes exactly 2^IDX_WIDTH cycles.
- IDLE:
  - req_ready=1 only in IDLE, and only when flush_req=0. flush_req has priority over a simultaneous request.
  - On accept: latch idx/tag, tr_re=1, tr_addr=req_idx (combinational from the request), go to CMP.
  - On flush_req: go to FLUSH.
- CMP (tr_rdata valid this cycle):
  - Way w hits when tag_w==latched tag AND valid_w. At most one way hits, guaranteed by the allocation policy.
  - Hit: rsp_hit=1, rsp_way=hit way.
  - Miss: the victim is the lowest-index invalid way; if all ways are valid, the victim is the victim pointer, and the pointer increments modulo WAYS.
  - Register the result, go to RSP.
- RSP:
  - rsp_valid=1, held stable until rsp_ready. Lookup latency: request accept -> rsp_valid = 2 cycles.
  - On handshake: hit -> IDLE; miss -> FILL.
- FILL:
  - Waits indefinitely for fill_done or fill_abort. If both are asserted, fill_abort wins.
  - fill_abort -> IDLE, no write.
  - fill_done -> WRITE.
  - flush_req is ignored in FILL, RSP and CMP (it is not latched, so the requester must hold or re-pulse it until busy=0).
- WRITE: one cycle; tr_addr=latched idx, tr_we=one-hot(victim way), tr_wdata={1, latched tag}; then IDLE.
- tr_we is 0 in all states except FLUSH and WRITE; tr_re is 1 only on the accept cycle.
- rst asserted in any state: immediate return to FLUSH. An in-flight response or fill is discarded and rsp_valid drops asynchronously.
- WAYS=1: rsp_way is always 0 and the victim pointer is constant.

Decomposition:
- mc_tag_pkg (or localparams shared with the cache top): state encoding (FLUSH, IDLE, CMP, RSP, FILL, WRITE) and the tag entry width TAG_WIDTH+1.
- Sub-module: mc_tag_match instantiated once per way. ref=latched tag, tag=way tag, valid=way valid bit, match=per-way hit.
- Victim selection (priority encoder plus pointer) stays inline.

Test Plan:
- Reset then idle, IDX_WIDTH=3 -> 8 consecutive cycles of tr_we=11, tr_addr 0..7, tr_wdata=0; busy falls on cycle 9; req_ready=1.
- Cold miss: req idx=5 tag=0x123, fill_done after 4 cycles -> rsp_hit=0, rsp_way=0; WRITE cycle with tr_addr=5, tr_we=01, tr_wdata=0x1123.
- Same request repeated -> rsp_valid exactly 2 cycles after accept, rsp_hit=1, rsp_way=0; no tr_we.
- Fill set 5 with tags 0x123 and 0x456, then miss tag 0x789 twice -> victims way 0 then way 1, from the round-robin pointer.
- Miss followed by fill_abort and fill_done in the same cycle -> no write; a later lookup of that tag misses again.
- flush_req together with req_valid in IDLE -> req_ready=0, full sweep runs; a prior hit tag now misses. Mid-FILL rst -> FLUSH restarts at addr 0, rsp_valid=0.
